rf_wr_arbiter: RTL and testbench

Write-port arbiter and bypass unit in front of the 32x32 register file.
- Two writeback requesters share the file's single write port: A is the ALU result path, B is the memory-load path.
- Each requester has a one-entry skid buffer. The block arbitrates between the buffers and drives a registered Awr/Din/WrEn stage into the register file.
- It also supplies forwarding data for both read addresses while writes are still pending.

---
 rtl/rf_wr_arbiter_if.sv | 35 +++
 rtl/rf_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_if.sv
// Write-request, commit and bypass signals between the writeback requesters and rf_wr_arbiter.
interface rf_wr_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          A_Valid;
    logic          A_Ready;
    logic [AW-1:0] A_Addr;
    logic [DW-1:0] A_Data;
    logic          B_Valid;
    logic          B_Ready;
    logic [AW-1:0] B_Addr;
    logic [DW-1:0] B_Data;
    logic          Hold;
    logic [AW-1:0] Awr;
    logic [DW-1:0] Din;
    logic          WrEn;
    logic [AW-1:0] Ard1;
    logic [AW-1:0] Ard2;
    logic          Fwd1_Hit;
    logic [DW-1:0] Fwd1_Data;
    logic          Fwd2_Hit;
    logic [DW-1:0] Fwd2_Data;
    logic          Busy;

    modport master (
        output A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data, Hold, Ard1, Ard2,
        input  A_Ready, B_Ready, Awr, Din, WrEn, Fwd1_Hit, Fwd1_Data, Fwd2_Hit, Fwd2_Data, Busy
    );

    modport slave (
        input  A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data, Hold, Ard1, Ard2,
        output A_Ready, B_Ready, Awr, Din, WrEn, Fwd1_Hit, Fwd1_Data, Fwd2_Hit, Fwd2_Data, Busy
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter with per-requester skid buffers and read bypass.
// Define RR_FAIR_EN for round-robin between distinct addresses; default is fixed B-before-A.
module rf_wr_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    rf_wr_arbiter_if.slave bus
);
    logic          a_v, b_v;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_older;
    logic          grant_a, grant_b, kill_a, kill_b;
    logic          load_a, load_b;
    logic [AW-1:0] awr_q;
    logic [DW-1:0] din_q;
    logic          wren_q;
    logic          y_v, o_v;
    logic [AW-1:0] y_addr, o_addr;
    logic [DW-1:0] y_data, o_data;
`ifdef RR_FAIR_EN
    logic          rr_b;
    logic          rr_upd;
`endif

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        kill_a  = 1'b0;
        kill_b  = 1'b0;
`ifdef RR_FAIR_EN
        rr_upd  = 1'b0;
`endif
        if (!bus.Hold) begin
            if (a_v && b_v) begin
                // Same destination: only the younger value survives, older dies unwritten.
                if (a_addr == b_addr) begin
                    if (a_older) begin
                        kill_a  = 1'b1;
                        grant_b = 1'b1;
                    end else begin
                        kill_b  = 1'b1;
                        grant_a = 1'b1;
                    end
                end else begin
`ifdef RR_FAIR_EN
                    rr_upd = 1'b1;
                    if (rr_b) grant_b = 1'b1;
                    else      grant_a = 1'b1;
`else
                    grant_b = 1'b1;
`endif
                end
            end else if (a_v) begin
                grant_a = 1'b1;
            end else if (b_v) begin
                grant_b = 1'b1;
            end
        end
    end

    assign bus.A_Ready = ~a_v | grant_a;
    assign bus.B_Ready = ~b_v | grant_b;
    assign load_a = bus.A_Valid & bus.A_Ready & (bus.A_Addr != '0);
    assign load_b = bus.B_Valid & bus.B_Ready & (bus.B_Addr != '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_v     <= 1'b0;
            b_v     <= 1'b0;
            a_addr  <= '0;
            b_addr  <= '0;
            a_data  <= '0;
            b_data  <= '0;
            a_older <= 1'b0;
            awr_q   <= '0;
            din_q   <= '0;
            wren_q  <= 1'b0;
`ifdef RR_FAIR_EN
            rr_b    <= 1'b1;
`endif
        end else begin
            if (load_a) begin
                a_v    <= 1'b1;
                a_addr <= bus.A_Addr;
                a_data <= bus.A_Data;
            end else if (grant_a || kill_a) begin
                a_v <= 1'b0;
            end
            if (load_b) begin
                b_v    <= 1'b1;
                b_addr <= bus.B_Addr;
                b_data <= bus.B_Data;
            end else if (grant_b || kill_b) begin
                b_v <= 1'b0;
            end
            // A fresh entry is always younger than whatever remains; a simultaneous pair ages A first.
            if (load_a && load_b)  a_older <= 1'b1;
            else if (load_a)       a_older <= 1'b0;
            else if (load_b)       a_older <= 1'b1;
            if (grant_a) begin
                awr_q  <= a_addr;
                din_q  <= a_data;
                wren_q <= 1'b1;
            end else if (grant_b) begin
                awr_q  <= b_addr;
                din_q  <= b_data;
                wren_q <= 1'b1;
            end else begin
                wren_q <= 1'b0;
            end
`ifdef RR_FAIR_EN
            if (rr_upd) rr_b <= grant_a;
`endif
        end
    end

    assign y_v    = a_older ? b_v    : a_v;
    assign y_addr = a_older ? b_addr : a_addr;
    assign y_data = a_older ? b_data : a_data;
    assign o_v    = a_older ? a_v    : b_v;
    assign o_addr = a_older ? a_addr : b_addr;
    assign o_data = a_older ? a_data : b_data;

    function automatic logic [DW:0] lookup(
        input logic [AW-1:0] ard,
        input logic yv, input logic [AW-1:0] ya, input logic [DW-1:0] yd,
        input logic ov, input logic [AW-1:0] oa, input logic [DW-1:0] od,
        input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd
    );
        lookup = '0;
        if (ard != '0) begin
            if (yv && ya == ard)      lookup = {1'b1, yd};
            else if (ov && oa == ard) lookup = {1'b1, od};
            else if (sv && sa == ard) lookup = {1'b1, sd};
        end
    endfunction

    always_comb begin
        {bus.Fwd1_Hit, bus.Fwd1_Data} = lookup(bus.Ard1, y_v, y_addr, y_data,
                                               o_v, o_addr, o_data, wren_q, awr_q, din_q);
        {bus.Fwd2_Hit, bus.Fwd2_Data} = lookup(bus.Ard2, y_v, y_addr, y_data,
                                               o_v, o_addr, o_data, wren_q, awr_q, din_q);
    end

    assign bus.Awr  = awr_q;
    assign bus.Din  = din_q;
    assign bus.WrEn = wren_q;
    assign bus.Busy = a_v | b_v | wren_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed vector bench for rf_wr_arbiter: per-cycle stimulus/expectation table plus reset and fairness sequences.
module tb_rf_wr_arbiter;
`ifdef RR_FAIR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rf_wr_arbiter_if #(.AW(5), .DW(32)) bus ();

    rf_wr_arbiter #(.AW(5), .DW(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        av;  logic [4:0] aa; logic [31:0] ad;
        logic        bv;  logic [4:0] ba; logic [31:0] bd;
        logic        hold; logic [4:0] r1; logic [4:0] r2;
        logic        ar;  logic br; logic we; logic [4:0] awr; logic [31:0] din;
        logic        h1;  logic [31:0] d1; logic h2; logic [31:0] d2; logic busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic hold, input logic [4:0] r1, input logic [4:0] r2);
        bus.A_Valid = av; bus.A_Addr = aa; bus.A_Data = ad;
        bus.B_Valid = bv; bus.B_Addr = ba; bus.B_Data = bd;
        bus.Hold = hold;  bus.Ard1 = r1;   bus.Ard2 = r2;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        //                 av aa  ad            bv ba  bd            hd r1  r2   ar br we awr din           h1 d1            h2 d2            busy
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 0,  0,   1, 1, 0, 0,  0,           0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{1, 5, 32'h11111111,0, 0,  0,           0, 5,  0,   1, 1, 0, 0,  0,           0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 5,  0,   1, 1, 0, 0,  0,           1, 32'h11111111,0, 0,           1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 5,  0,   1, 1, 1, 5,  32'h11111111,1, 32'h11111111,0, 0,           1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 5,  0,   1, 1, 0, 5,  32'h11111111,0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{1, 3, 32'hAAAA0000,1, 4,  32'hBBBB0000,0, 3,  4,   1, 1, 0, 5,  32'h11111111,0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 3,  4,   0, 1, 0, 5,  32'h11111111,1, 32'hAAAA0000,1, 32'hBBBB0000,1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 3,  4,   1, 1, 1, 4,  32'hBBBB0000,1, 32'hAAAA0000,1, 32'hBBBB0000,1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 3,  4,   1, 1, 1, 3,  32'hAAAA0000,1, 32'hAAAA0000,0, 0,           1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 3,  4,   1, 1, 0, 3,  32'hAAAA0000,0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{1, 7, 1,           1, 7,  2,           0, 7,  0,   1, 1, 0, 3,  32'hAAAA0000,0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 7,  0,   0, 1, 0, 3,  32'hAAAA0000,1, 2,           0, 0,           1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 7,  0,   1, 1, 1, 7,  2,           1, 2,           0, 0,           1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 7,  0,   1, 1, 0, 7,  2,           0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{1, 10,32'hA0A0A0A0,1, 11, 32'hB1B1B1B1,1, 10, 11,  1, 1, 0, 7,  2,           0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{1, 10,32'hA0A0A0A0,1, 11, 32'hB1B1B1B1,1, 10, 11,  0, 0, 0, 7,  2,           1, 32'hA0A0A0A0,1, 32'hB1B1B1B1,1});
        tbl.push_back(vec_t'{1, 10,32'hA0A0A0A0,1, 11, 32'hB1B1B1B1,1, 10, 11,  0, 0, 0, 7,  2,           1, 32'hA0A0A0A0,1, 32'hB1B1B1B1,1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 10, 11,  RR, !RR, 0, 7, 2,         1, 32'hA0A0A0A0,1, 32'hB1B1B1B1,1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 10, 11,  1, 1, 1, RR ? 5'd10 : 5'd11,
                             RR ? 32'hA0A0A0A0 : 32'hB1B1B1B1,      1, 32'hA0A0A0A0,1, 32'hB1B1B1B1,1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 10, 11,  1, 1, 1, RR ? 5'd11 : 5'd10,
                             RR ? 32'hB1B1B1B1 : 32'hA0A0A0A0,      !RR, RR ? 32'h0 : 32'hA0A0A0A0,
                             RR, RR ? 32'hB1B1B1B1 : 32'h0,         1});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 10, 11,  1, 1, 0, RR ? 5'd11 : 5'd10,
                             RR ? 32'hB1B1B1B1 : 32'hA0A0A0A0,      0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{1, 0, 32'hFFFFFFFF,0, 0,  0,           0, 0,  0,   1, 1, 0, RR ? 5'd11 : 5'd10,
                             RR ? 32'hB1B1B1B1 : 32'hA0A0A0A0,      0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 0,  0,   1, 1, 0, RR ? 5'd11 : 5'd10,
                             RR ? 32'hB1B1B1B1 : 32'hA0A0A0A0,      0, 0,           0, 0,           0});
        tbl.push_back(vec_t'{0, 0, 0,           0, 0,  0,           0, 0,  0,   1, 1, 0, RR ? 5'd11 : 5'd10,
                             RR ? 32'hB1B1B1B1 : 32'hA0A0A0A0,      0, 0,           0, 0,           0});

        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge Clk);
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
                  tbl[i].hold, tbl[i].r1, tbl[i].r2);
            #1;
            chk($sformatf("v%0d.a_ready", i), 32'(bus.A_Ready), 32'(tbl[i].ar));
            chk($sformatf("v%0d.b_ready", i), 32'(bus.B_Ready), 32'(tbl[i].br));
            chk($sformatf("v%0d.wren", i),    32'(bus.WrEn),    32'(tbl[i].we));
            chk($sformatf("v%0d.awr", i),     32'(bus.Awr),     32'(tbl[i].awr));
            chk($sformatf("v%0d.din", i),     bus.Din,          tbl[i].din);
            chk($sformatf("v%0d.fwd1_hit", i),32'(bus.Fwd1_Hit),32'(tbl[i].h1));
            chk($sformatf("v%0d.fwd1_data", i), bus.Fwd1_Data,  tbl[i].d1);
            chk($sformatf("v%0d.fwd2_hit", i),32'(bus.Fwd2_Hit),32'(tbl[i].h2));
            chk($sformatf("v%0d.fwd2_data", i), bus.Fwd2_Data,  tbl[i].d2);
            chk($sformatf("v%0d.busy", i),    32'(bus.Busy),    32'(tbl[i].busy));
        end

`ifdef RR_FAIR_EN
        // Pointer favours B here: first pair commits B, the repeated pair commits A.
        @(negedge Clk); drive(1, 3, 32'hAAAA0000, 1, 4, 32'hBBBB0000, 0, 0, 0);
        @(negedge Clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rr1.b_first", 32'(bus.B_Ready), 32'd1);
        chk("rr1.a_wait",  32'(bus.A_Ready), 32'd0);
        repeat (3) @(negedge Clk);
        drive(1, 3, 32'hAAAA0000, 1, 4, 32'hBBBB0000, 0, 0, 0);
        @(negedge Clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rr2.a_first", 32'(bus.A_Ready), 32'd1);
        chk("rr2.b_wait",  32'(bus.B_Ready), 32'd0);
        @(negedge Clk); #1;
        chk("rr2.awr", 32'(bus.Awr), 32'd3);
        chk("rr2.din", bus.Din, 32'hAAAA0000);
        repeat (3) @(negedge Clk);
`endif

        // Reset while r12 is on the write stage and r9 waits in buffer B.
        @(negedge Clk); drive(1, 12, 32'hC0C0C0C0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk); drive(0, 0, 0, 1, 9, 32'h99999999, 0, 0, 0);
        @(negedge Clk); drive(0, 0, 0, 0, 0, 0, 0, 9, 0); #1;
        chk("rst.pre_wren", 32'(bus.WrEn), 32'd1);
        chk("rst.pre_awr",  32'(bus.Awr),  32'd12);
        chk("rst.pre_hit",  32'(bus.Fwd1_Hit), 32'd1);
        chk("rst.pre_data", bus.Fwd1_Data, 32'h99999999);
        Rst = 1'b1; #1;
        chk("rst.wren", 32'(bus.WrEn), 32'd0);
        chk("rst.busy", 32'(bus.Busy), 32'd0);
        chk("rst.hit",  32'(bus.Fwd1_Hit), 32'd0);
        chk("rst.awr",  32'(bus.Awr), 32'd0);
        chk("rst.din",  bus.Din, 32'd0);
        @(negedge Clk); Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); #1;
            chk($sformatf("rst.post%0d.wren", k), 32'(bus.WrEn), 32'd0);
            chk($sformatf("rst.post%0d.busy", k), 32'(bus.Busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
